// File: rtl/event_enc_pkg.sv
// Shared constants, output-stage state type and a one-hot helper for the 8-to-3 event encoder.
package event_enc_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/event_encoder_8to3_prio_pick8.sv
// Combinational picker: returns the first set bit of i_vec, searching upward from i_start and wrapping 7->0.
module prio_pick8
    import event_enc_pkg::*;
(
    input  logic [N_REQ-1:0]  i_vec,
    input  logic [CODE_W-1:0] i_start,
    output logic              o_found,
    output logic [CODE_W-1:0] o_idx
);

    logic [CODE_W-1:0] w_pos;

    // Walk from the farthest offset down so the nearest hit overwrites earlier ones.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_pos = i_start + CODE_W'(k);
            if (i_vec[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/event_encoder_8to3.sv
// Event encoder: latches request pulses into a pending set and hands them out one code at a time
// through a valid/ready stage. Define EVENT_ENC_ROUND_ROBIN_EN for round-robin arbitration.
module event_encoder_8to3
    import event_enc_pkg::*;
#(
    parameter int N_REQ = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    input  logic              code_ready,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic              busy
);

    stage_t            r_state;
    stage_t            w_stateNext;
    logic [N_REQ-1:0]  r_pending;
    logic [CODE_W-1:0] r_code;
    logic              r_ovf;

    logic              w_transfer;
    logic              w_load;
    logic              w_found;
    logic [CODE_W-1:0] w_idx;
    logic [CODE_W-1:0] w_start;
    logic [N_REQ-1:0]  w_clearMask;
    logic [N_REQ-1:0]  w_pendingKept;
    logic              w_ovfSet;

`ifdef EVENT_ENC_ROUND_ROBIN_EN
    logic [CODE_W-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= CODE_W'(N_REQ - 1);
        end else if (w_load) begin
            r_ptr <= w_idx;
        end
    end

    assign w_start = r_ptr + 1'b1;
`else
    assign w_start = '0;
`endif

    prio_pick8 u_pick (
        .i_vec   (r_pending),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    assign w_transfer = (r_state == FULL) && code_ready;

    // Output stage: load whenever the slot is free or is being drained this edge.
    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_found) begin
                    w_stateNext = FULL;
                    w_load      = 1'b1;
                end
            end
            FULL: begin
                if (w_transfer) begin
                    if (w_found) begin
                        w_load = 1'b1;
                    end else begin
                        w_stateNext = EMPTY;
                    end
                end
            end
            default: begin
                w_stateNext = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A bit being granted this edge is not a collision: a fresh request simply re-arms it.
    assign w_clearMask   = w_load ? onehot(w_idx) : '0;
    assign w_pendingKept = r_pending & ~w_clearMask;
    assign w_ovfSet      = |(req & w_pendingKept);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_code    <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_pending <= w_pendingKept | req;
            if (w_load) begin
                r_code <= w_idx;
            end
            if (w_ovfSet) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign code       = r_code;
    assign code_valid = (r_state == FULL);
    assign ovf        = r_ovf;
    assign busy       = (|r_pending) || code_valid;

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Directed self-checking bench for event_encoder_8to3 in its default (fixed-priority) build.
module tb_event_encoder_8to3;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [2:0] code;
    logic       code_valid;
    logic       code_ready;
    logic       ovf;
    logic       ovf_clr;
    logic       busy;

    int nTotal;
    int nBad;

    event_encoder_8to3 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, clock it in, then settle just after the edge.
    task automatic applyStimulus(input logic [7:0] r, input logic rdy, input logic clr);
        req        = r;
        code_ready = rdy;
        ovf_clr    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        nTotal++;
        if (observed !== expected) begin
            nBad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Checks the valid flag and, when valid is expected, the code too.
    task automatic checkStage(input string tag, input logic expValid, input logic [2:0] expCode);
        checkOutput({tag, ".valid"}, {7'd0, code_valid}, {7'd0, expValid});
        if (expValid) begin
            checkOutput({tag, ".code"}, {5'd0, code}, {5'd0, expCode});
        end
    endtask

    initial begin
        nTotal     = 0;
        nBad       = 0;
        rst_n      = 1'b0;
        req        = '0;
        code_ready = 1'b0;
        ovf_clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.valid", {7'd0, code_valid}, 8'd0);
        checkOutput("reset.code", {5'd0, code}, 8'd0);
        checkOutput("reset.ovf", {7'd0, ovf}, 8'd0);
        checkOutput("reset.busy", {7'd0, busy}, 8'd0);
        rst_n = 1'b1;

        // Single event: code 5 appears two edges after the request, for one cycle.
        applyStimulus(8'h20, 1'b1, 1'b0);
        checkStage("single.e1", 1'b0, 3'd0);
        checkOutput("single.e1.busy", {7'd0, busy}, 8'd1);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkStage("single.e2", 1'b1, 3'd5);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkStage("single.e3", 1'b0, 3'd0);
        checkOutput("single.idle.busy", {7'd0, busy}, 8'd0);

        // Multi event: lowest index first, back-to-back.
        applyStimulus(8'h85, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkStage("multi.c0", 1'b1, 3'd0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkStage("multi.c2", 1'b1, 3'd2);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkStage("multi.c7", 1'b1, 3'd7);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkStage("multi.end", 1'b0, 3'd0);
        checkOutput("multi.busy", {7'd0, busy}, 8'd0);

        // Backpressure: code 0 held while the consumer stalls.
        applyStimulus(8'h03, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkStage("bp.load", 1'b1, 3'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h00, 1'b0, 1'b0);
            checkStage("bp.hold", 1'b1, 3'd0);
        end
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkStage("bp.next", 1'b1, 3'd1);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkStage("bp.end", 1'b0, 3'd0);
        checkOutput("bp.ovf", {7'd0, ovf}, 8'd0);

        // Overflow: req[3] twice while code 0 is stalled.
        applyStimulus(8'h01, 1'b0, 1'b0);
        applyStimulus(8'h08, 1'b0, 1'b0);
        checkStage("ovf.stall", 1'b1, 3'd0);
        checkOutput("ovf.first", {7'd0, ovf}, 8'd0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        applyStimulus(8'h08, 1'b0, 1'b0);
        checkOutput("ovf.set", {7'd0, ovf}, 8'd1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("ovf.sticky", {7'd0, ovf}, 8'd1);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("ovf.clr", {7'd0, ovf}, 8'd0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkStage("ovf.code3", 1'b1, 3'd3);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkStage("ovf.once", 1'b0, 3'd0);

        // Collision: re-request of bit 2 on the edge it is granted.
        applyStimulus(8'h04, 1'b1, 1'b0);
        applyStimulus(8'h04, 1'b1, 1'b0);
        checkStage("coll.first", 1'b1, 3'd2);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkStage("coll.second", 1'b1, 3'd2);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkStage("coll.end", 1'b0, 3'd0);
        checkOutput("coll.ovf", {7'd0, ovf}, 8'd0);

        // Asynchronous reset with a grant held and 0xF0 still pending.
        applyStimulus(8'h01, 1'b0, 1'b0);
        applyStimulus(8'hF0, 1'b0, 1'b0);
        checkStage("rst.before", 1'b1, 3'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst.async.valid", {7'd0, code_valid}, 8'd0);
        checkOutput("rst.async.busy", {7'd0, busy}, 8'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h00, 1'b1, 1'b0);
            checkStage("rst.after", 1'b0, 3'd0);
        end
        checkOutput("rst.after.busy", {7'd0, busy}, 8'd0);

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
